// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a register bank with a sequenced clear sweep.
// Grants at most one requester per cycle and drives a shared one-hot load strobe.
module reg_write_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREG = 8,
  parameter int unsigned NREQ = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   req,
  input  logic [NREQ*$clog2(NREG)-1:0]      addr,
  input  logic [NREQ*N-1:0]                 wdata,
  input  logic                              clr_start,
  output logic [NREQ-1:0]                   gnt,
  output logic [NREG-1:0]                   load,
  output logic [N-1:0]                      WriteData,
  output logic                              clr_busy
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned RW = $clog2(NREQ);
  localparam int unsigned CW = RW + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]      state, state_n;
  logic [AW-1:0]   sweep_idx, sweep_n;
  logic [RW-1:0]   last_gnt, last_n;
  logic [NREQ-1:0] gnt_n;
  logic [NREG-1:0] load_n;
  logic [N-1:0]    wdata_n;
  logic            busy_n;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [RW-1:0]   win;
  logic [CW-1:0]   cand;
  logic [AW-1:0]   win_addr;
  logic [N-1:0]    win_data;

  // Round-robin search starting just after the last granted requester.
  // A requester granted last cycle is masked so it cannot win twice in a row.
  always_comb begin
    elig  = req & ~gnt;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = CW'(last_gnt) + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!found && elig[cand[RW-1:0]]) begin
        found = 1'b1;
        win   = cand[RW-1:0];
      end
    end
  end

  assign win_addr = addr[32'(win)*AW +: AW];
  assign win_data = wdata[32'(win)*N +: N];

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sweep_idx <= '0;
      last_gnt  <= RW'(NREQ-1);
      gnt       <= '0;
      load      <= '0;
      WriteData <= '0;
      clr_busy  <= 1'b0;
    end else begin
      state     <= state_n;
      sweep_idx <= sweep_n;
      last_gnt  <= last_n;
      gnt       <= gnt_n;
      load      <= load_n;
      WriteData <= wdata_n;
      clr_busy  <= busy_n;
    end
  end

  // Next-state and next-output logic; arbitration resumes on the edge closing the sweep.
  always_comb begin
    state_n = state;
    sweep_n = sweep_idx;
    last_n  = last_gnt;
    gnt_n   = '0;
    load_n  = '0;
    wdata_n = WriteData;
    busy_n  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_n = CLEAR;
          sweep_n = '0;
          load_n  = NREG'(1);
          wdata_n = '0;
          busy_n  = 1'b1;
        end else if (found) begin
          gnt_n   = NREQ'(1) << win;
          load_n  = NREG'(1) << win_addr;
          wdata_n = win_data;
          last_n  = win;
        end
      end
      CLEAR: begin
        if (sweep_idx == AW'(NREG-1)) begin
          state_n = IDLE;
          sweep_n = '0;
          if (found) begin
            gnt_n   = NREQ'(1) << win;
            load_n  = NREG'(1) << win_addr;
            wdata_n = win_data;
            last_n  = win;
          end
        end else begin
          sweep_n = sweep_idx + 1'b1;
          load_n  = NREG'(1) << sweep_n;
          wdata_n = '0;
          busy_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter: reset, single write, fairness,
// clear priority, reset during clear and self-masking.
module tb_reg_write_arbiter;

  localparam int unsigned N    = 32;
  localparam int unsigned NREG = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 3;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*N-1:0]    wdata;
  logic                 clr_start;
  logic [NREQ-1:0]      gnt;
  logic [NREG-1:0]      load;
  logic [N-1:0]         WriteData;
  logic                 clr_busy;

  int vectors;
  int miscompares;

  reg_write_arbiter #(.N(N), .NREG(NREG), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .clr_start (clr_start),
    .gnt       (gnt),
    .load      (load),
    .WriteData (WriteData),
    .clr_busy  (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [N-1:0] d);
    addr[i*AW +: AW] = a;
    wdata[i*N +: N]  = d;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (gnt !== 4'b0) begin miscompares++; $display("FAIL reset_init_gnt: got %b expected %b", gnt, 4'b0); end
    vectors++; if (load !== 8'b0) begin miscompares++; $display("FAIL reset_init_load: got %b expected %b", load, 8'b0); end
    vectors++; if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL reset_init_busy: got %b expected %b", clr_busy, 1'b0); end
    set_req(0, 3'd1, 32'h1111_0000);
    req = 4'b1111;
    #10 rst = 1'b1;
    tick();
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL first_arb_gnt: got %b expected %b", gnt, 4'b0001); end
    vectors++; if (load !== 8'b0000_0010) begin miscompares++; $display("FAIL first_arb_load: got %b expected %b", load, 8'b0000_0010); end
    vectors++; if (WriteData !== 32'h1111_0000) begin miscompares++; $display("FAIL first_arb_wd: got %h expected %h", WriteData, 32'h1111_0000); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (gnt !== 4'b0) begin miscompares++; $display("FAIL async_rst_gnt: got %b expected %b", gnt, 4'b0); end
    vectors++; if (load !== 8'b0) begin miscompares++; $display("FAIL async_rst_load: got %b expected %b", load, 8'b0); end
    vectors++; if (WriteData !== 32'h0) begin miscompares++; $display("FAIL async_rst_wd: got %h expected %h", WriteData, 32'h0); end
    vectors++; if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL async_rst_busy: got %b expected %b", clr_busy, 1'b0); end
    #2 rst = 1'b1;
    req = 4'b0;
  endtask

  task automatic test_single_write();
    set_req(2, 3'd5, 32'hDEAD_BEEF);
    req = 4'b0100;
    tick();
    vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt: got %b expected %b", gnt, 4'b0100); end
    vectors++; if (load !== 8'b0010_0000) begin miscompares++; $display("FAIL single_load: got %b expected %b", load, 8'b0010_0000); end
    vectors++; if (WriteData !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_wd: got %h expected %h", WriteData, 32'hDEAD_BEEF); end
    req = 4'b0;
    tick();
    vectors++; if (gnt !== 4'b0) begin miscompares++; $display("FAIL single_gnt_drop: got %b expected %b", gnt, 4'b0); end
    vectors++; if (load !== 8'b0) begin miscompares++; $display("FAIL single_load_drop: got %b expected %b", load, 8'b0); end
    vectors++; if (WriteData !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_wd_hold: got %h expected %h", WriteData, 32'hDEAD_BEEF); end
  endtask

  task automatic test_fairness();
    logic [3:0]  eg [5];
    logic [7:0]  el [5];
    logic [31:0] ew [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    el = '{8'b1000_0000, 8'b0100_0000, 8'b0010_0000, 8'b0001_0000, 8'b1000_0000};
    ew = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0000};
    for (int i = 0; i < 4; i++) set_req(i, AW'(7 - i), 32'hA000_0000 + 32'(i));
    req = 4'b1111;
    rst = 1'b0;
    #2 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++; if (gnt !== eg[c]) begin miscompares++; $display("FAIL fair_gnt[%0d]: got %b expected %b", c, gnt, eg[c]); end
      vectors++; if (load !== el[c]) begin miscompares++; $display("FAIL fair_load[%0d]: got %b expected %b", c, load, el[c]); end
      vectors++; if (WriteData !== ew[c]) begin miscompares++; $display("FAIL fair_wd[%0d]: got %h expected %h", c, WriteData, ew[c]); end
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_clear_priority();
    logic [7:0] exp_l;
    req = 4'b0001;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      if (k == 3) clr_start = 1'b0;
      exp_l = 8'b1 << k;
      vectors++; if (load !== exp_l) begin miscompares++; $display("FAIL clr_load[%0d]: got %b expected %b", k, load, exp_l); end
      vectors++; if (WriteData !== 32'h0) begin miscompares++; $display("FAIL clr_wd[%0d]: got %h expected %h", k, WriteData, 32'h0); end
      vectors++; if (clr_busy !== 1'b1) begin miscompares++; $display("FAIL clr_busy[%0d]: got %b expected %b", k, clr_busy, 1'b1); end
      vectors++; if (gnt !== 4'b0) begin miscompares++; $display("FAIL clr_gnt[%0d]: got %b expected %b", k, gnt, 4'b0); end
      if (k == 2) clr_start = 1'b1;
    end
    tick();
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL post_clr_gnt: got %b expected %b", gnt, 4'b0001); end
    vectors++; if (load !== 8'b1000_0000) begin miscompares++; $display("FAIL post_clr_load: got %b expected %b", load, 8'b1000_0000); end
    vectors++; if (WriteData !== 32'hA000_0000) begin miscompares++; $display("FAIL post_clr_wd: got %h expected %h", WriteData, 32'hA000_0000); end
    vectors++; if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL post_clr_busy: got %b expected %b", clr_busy, 1'b0); end
    req = 4'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (3) tick();
    vectors++; if (load !== 8'b0000_1000) begin miscompares++; $display("FAIL midclr_load: got %b expected %b", load, 8'b0000_1000); end
    vectors++; if (clr_busy !== 1'b1) begin miscompares++; $display("FAIL midclr_busy: got %b expected %b", clr_busy, 1'b1); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (load !== 8'b0) begin miscompares++; $display("FAIL midclr_rst_load: got %b expected %b", load, 8'b0); end
    vectors++; if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL midclr_rst_busy: got %b expected %b", clr_busy, 1'b0); end
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (load !== 8'b0) begin miscompares++; $display("FAIL after_abort_load[%0d]: got %b expected %b", c, load, 8'b0); end
      vectors++; if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL after_abort_busy[%0d]: got %b expected %b", c, clr_busy, 1'b0); end
    end
  endtask

  task automatic test_self_mask();
    logic [3:0] eg [4];
    logic [7:0] el [4];
    eg = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
    el = '{8'b0000_0100, 8'b0000_0000, 8'b0000_0100, 8'b0000_0000};
    set_req(1, 3'd2, 32'h0BAD_F00D);
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if (gnt !== eg[c]) begin miscompares++; $display("FAIL mask_gnt[%0d]: got %b expected %b", c, gnt, eg[c]); end
      vectors++; if (load !== el[c]) begin miscompares++; $display("FAIL mask_load[%0d]: got %b expected %b", c, load, el[c]); end
      vectors++; if (WriteData !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL mask_wd[%0d]: got %h expected %h", c, WriteData, 32'h0BAD_F00D); end
    end
    req = 4'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    req         = '0;
    addr        = '0;
    wdata       = '0;
    clr_start   = 1'b0;
    test_reset();
    test_single_write();
    test_fairness();
    test_clear_priority();
    test_reset_mid_clear();
    test_self_mask();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
